fu0_writeback: RTL and testbench
================================

Name: fu0_writeback

Overview:
- Receiving end of the FU0 output packet.
- Registers the ALU result for one cycle and drives the physical-register-file write port and the bypass/wakeup broadcast.
- Buffers completion records (active-list id, execution flags, branch mask) in a small queue toward the active list, which can back-pressure.
- Applies branch squash (mispredict) and branch-mask clearing (correct prediction) to both the writeback register and the queued records.

Parameters:
- CQ_DEPTH, 4, completion-queue entries (power of two, ≥2).
- CQ_LOG, 2, log2(CQ_DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fuPacket_i  in  CHECKPOINTS+EXECUTION_FLAGS+SIZE_PHYSICAL_LOG+SIZE_ACTIVELIST_LOG+SIZE_DATA+SIZE_ISSUEQ_LOG+SIZE_LSQ_LOG+CHECKPOINTS_LOG+SIZE_CTI_LOG+SIZE_PC+1  FU0 packet.
  - Fields, MSB→LSB: {branchMask, flags, destReg, ALid, result, IQentry, LSQid, SMTid, ctiqTag, tarAddr, brDir}.
- fuValid_i  in  1  packet valid.
- ctrlVerified_i  in  1  branch resolved this cycle.
- ctrlMispredict_i  in  1  resolved branch mispredicted.
- ctrlSMTid_i  in  CHECKPOINTS_LOG  checkpoint id of the resolved branch.
- cmplReady_i  in  1  active list accepts a completion record.
- rfWrEn_o  out  1  PRF write enable.
- rfWrAddr_o  out  SIZE_PHYSICAL_LOG  PRF write address.
- rfWrData_o  out  SIZE_DATA  PRF write data.
- bypassValid_o  out  1  bypass/wakeup valid (equals rfWrEn_o).
- bypassTag_o  out  SIZE_PHYSICAL_LOG  bypass tag.
- bypassData_o  out  SIZE_DATA  bypass data.
- cmplValid_o  out  1  head completion record valid.
- cmplALid_o  out  SIZE_ACTIVELIST_LOG  head active-list id.
- cmplFlags_o  out  EXECUTION_FLAGS  head execution flags.
- fuReady_o  out  1  issue may send FU0 an instruction this cycle.
- overflow_o  out  1  sticky error: push into a full queue.

Behaviour:
- Squash condition:
  - kill(mask) = ctrlVerified_i & ctrlMispredict_i & mask[ctrlSMTid_i].
  - clr = ctrlVerified_i & ~ctrlMispredict_i.
  - On clr, bit ctrlSMTid_i is cleared in every stored mask in the same edge.
- Input acceptance:
  - accept = fuValid_i & ~kill(fuPacket_i.branchMask).
  - Accepted packets load the W register and push the queue in the same edge.
  - The pushed mask already has the clr applied.
- W register (latency 1):
  - Holds {valid, destReg, result, mask}.
  - Next valid = accept. Each cycle it either loads a new packet or clears.
  - If W is valid and kill(W.mask) holds this cycle, rfWrEn_o/bypassValid_o are forced to 0 combinationally; no write occurs.
  - Otherwise rfWrEn_o = bypassValid_o = W.valid, with address/tag = W.destReg and data = W.result.
- Completion queue: circular, head/tail pointers of width CQ_LOG, count of width CQ_LOG+1. Entry = {live, mask, flags, ALid}.
  - Mispredict: every entry with kill(mask) set gets live=0 at the edge.
  - Head handling:
    - live head: cmplValid_o=1; pops on cmplReady_i.
    - dead head: cmplValid_o=0; pops unconditionally, one per cycle.
  - Simultaneous push and pop: count unchanged; push is allowed when full if a pop occurs that cycle.
  - Push when full without a pop: entry dropped, overflow_o set until reset.
  - Pointers wrap modulo CQ_DEPTH.
- fuReady_o = (count ≤ CQ_DEPTH-2), combinational from registered count. This covers one in-flight issue cycle.
- Reset:
  - W invalid, queue empty, pointers 0, overflow_o=0.
  - All data outputs 0; cmplValid_o=0; fuReady_o=1.
  - Reset dominates any concurrent push, pop or squash.

Decomposition:
- Shared package/defines: packet field offsets (FU_PKT_MASK_LSB, FU_PKT_FLAGS_LSB, …, FU_PKT_WIDTH) derived from the existing size defines, so FU0 and this block use identical slicing.
- One sub-module: fu_cmpl_queue.
  - Parameterised queue with per-entry branch-mask clear and kill.
  - Reusable by the other FU writeback blocks.

Test Plan:
- Single valid packet (destReg=5, result=0x1234, ALid=3, mask=0):
  - Next cycle rfWrEn_o=1, rfWrAddr_o=5, rfWrData_o=0x1234, bypassValid_o=1.
  - With cmplReady_i=1: cmplValid_o=1, cmplALid_o=3; queue empty one cycle later.
- Packet with mask bit 2 set, sent in the same cycle as mispredict on SMTid=2:
  - No PRF write, no completion, count stays 0.
- Back-pressure (cmplReady_i=0), packets issued while fuReady_o=1:
  - fuReady_o drops once count=3.
  - Forcing a 5th push sets overflow_o=1.
  - Releasing cmplReady_i drains ALids in order.
- Queue holding ALid 1 (mask bit 1) and ALid 2 (mask 0), cmplReady_i=0, then mispredict on SMTid=1:
  - Entry 1 dropped silently.
  - cmplValid_o next shows ALid 2.
- Correct verify (ctrlVerified_i=1, ctrlMispredict_i=0) on SMTid=1, then a later mispredict on SMTid=1:
  - Queued entry survives and completes.
- Assert reset while queue is full and W is valid:
  - Next cycle all outputs 0, fuReady_o=1, overflow_o=0.

Source files
------------

// File: rtl/fu0_writeback_pkg.sv
// fu0_writeback_pkg: shared FU packet sizes, field offsets, packet struct and branch-mask helpers
package fu0_writeback_pkg;
  localparam int CHECKPOINTS = 4;
  localparam int CHECKPOINTS_LOG = 2;
  localparam int EXECUTION_FLAGS = 4;
  localparam int SIZE_PHYSICAL_LOG = 7;
  localparam int SIZE_ACTIVELIST_LOG = 6;
  localparam int SIZE_DATA = 32;
  localparam int SIZE_ISSUEQ_LOG = 5;
  localparam int SIZE_LSQ_LOG = 5;
  localparam int SIZE_CTI_LOG = 4;
  localparam int SIZE_PC = 32;
  localparam int FU_PKT_BRDIR_LSB = 0;
  localparam int FU_PKT_TARADDR_LSB = FU_PKT_BRDIR_LSB + 1;
  localparam int FU_PKT_CTIQ_LSB = FU_PKT_TARADDR_LSB + SIZE_PC;
  localparam int FU_PKT_SMTID_LSB = FU_PKT_CTIQ_LSB + SIZE_CTI_LOG;
  localparam int FU_PKT_LSQID_LSB = FU_PKT_SMTID_LSB + CHECKPOINTS_LOG;
  localparam int FU_PKT_IQENTRY_LSB = FU_PKT_LSQID_LSB + SIZE_LSQ_LOG;
  localparam int FU_PKT_RESULT_LSB = FU_PKT_IQENTRY_LSB + SIZE_ISSUEQ_LOG;
  localparam int FU_PKT_ALID_LSB = FU_PKT_RESULT_LSB + SIZE_DATA;
  localparam int FU_PKT_DEST_LSB = FU_PKT_ALID_LSB + SIZE_ACTIVELIST_LOG;
  localparam int FU_PKT_FLAGS_LSB = FU_PKT_DEST_LSB + SIZE_PHYSICAL_LOG;
  localparam int FU_PKT_MASK_LSB = FU_PKT_FLAGS_LSB + EXECUTION_FLAGS;
  localparam int FU_PKT_WIDTH = FU_PKT_MASK_LSB + CHECKPOINTS;
  typedef struct packed {
    logic [CHECKPOINTS-1:0] branchMask;
    logic [EXECUTION_FLAGS-1:0] flags;
    logic [SIZE_PHYSICAL_LOG-1:0] destReg;
    logic [SIZE_ACTIVELIST_LOG-1:0] ALid;
    logic [SIZE_DATA-1:0] result;
    logic [SIZE_ISSUEQ_LOG-1:0] IQentry;
    logic [SIZE_LSQ_LOG-1:0] LSQid;
    logic [CHECKPOINTS_LOG-1:0] SMTid;
    logic [SIZE_CTI_LOG-1:0] ctiqTag;
    logic [SIZE_PC-1:0] tarAddr;
    logic brDir;
  } fuPkt_t;
  function automatic logic killHit(logic [CHECKPOINTS-1:0] m, logic ver, logic misp, logic [CHECKPOINTS_LOG-1:0] id);
    return ver & misp & m[id];
  endfunction
  function automatic logic [CHECKPOINTS-1:0] clrMask(logic ver, logic misp, logic [CHECKPOINTS_LOG-1:0] id);
    return (ver & ~misp) ? ~(CHECKPOINTS'(1) << id) : '1;
  endfunction
endpackage

// File: rtl/fu0_writeback_if.sv
// fu0_writeback_if: FU0 packet in, branch resolve in, PRF write/bypass out, completion handshake out
interface fu0_writeback_if;
  import fu0_writeback_pkg::*;
  logic [FU_PKT_WIDTH-1:0] fuPacket_i;
  logic fuValid_i;
  logic ctrlVerified_i;
  logic ctrlMispredict_i;
  logic [CHECKPOINTS_LOG-1:0] ctrlSMTid_i;
  logic cmplReady_i;
  logic rfWrEn_o;
  logic [SIZE_PHYSICAL_LOG-1:0] rfWrAddr_o;
  logic [SIZE_DATA-1:0] rfWrData_o;
  logic bypassValid_o;
  logic [SIZE_PHYSICAL_LOG-1:0] bypassTag_o;
  logic [SIZE_DATA-1:0] bypassData_o;
  logic cmplValid_o;
  logic [SIZE_ACTIVELIST_LOG-1:0] cmplALid_o;
  logic [EXECUTION_FLAGS-1:0] cmplFlags_o;
  logic fuReady_o;
  logic overflow_o;
  modport master (
    output fuPacket_i, fuValid_i, ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i, cmplReady_i,
    input rfWrEn_o, rfWrAddr_o, rfWrData_o, bypassValid_o, bypassTag_o, bypassData_o,
    input cmplValid_o, cmplALid_o, cmplFlags_o, fuReady_o, overflow_o
  );
  modport slave (
    input fuPacket_i, fuValid_i, ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i, cmplReady_i,
    output rfWrEn_o, rfWrAddr_o, rfWrData_o, bypassValid_o, bypassTag_o, bypassData_o,
    output cmplValid_o, cmplALid_o, cmplFlags_o, fuReady_o, overflow_o
  );
endinterface

// File: rtl/fu_cmpl_queue.sv
// fu_cmpl_queue: circular completion queue (push/pop/count/overflow) with per-entry branch-mask clear and kill; dead heads drain one per cycle
module fu_cmpl_queue #(
  parameter int DEPTH = 4,
  parameter int LOG = 2,
  parameter int MASK_W = 4,
  parameter int ID_W = 2,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pushEn,
  input  logic [MASK_W-1:0] pushMask,
  input  logic [DATA_W-1:0] pushData,
  input  logic              verified,
  input  logic              mispredict,
  input  logic [ID_W-1:0]   brId,
  input  logic              popReady,
  output logic              headValid,
  output logic [DATA_W-1:0] headData,
  output logic [LOG:0]      count,
  output logic              overflow
);
  logic [DEPTH-1:0] live;
  logic [MASK_W-1:0] mask [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [LOG-1:0] head, tail;
  logic [MASK_W-1:0] keepMask;
  logic pop, full, doPush;
  assign keepMask = (verified & ~mispredict) ? ~(MASK_W'(1) << brId) : '1;
  assign headValid = (count != '0) & live[head];
  assign headData = headValid ? data[head] : '0;
  assign pop = (count != '0) & (~live[head] | popReady);
  assign full = count == (LOG+1)'(DEPTH);
  assign doPush = pushEn & (~full | pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      overflow <= 1'b0;
      live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mask[i] <= mask[i] & keepMask;
        if (verified & mispredict & mask[i][brId]) live[i] <= 1'b0;
      end
      if (pop) begin
        head <= head + 1'b1;
        live[head] <= 1'b0;
      end
      // push comes last so a full queue popping and pushing into the same slot keeps the new entry
      if (doPush) begin
        tail <= tail + 1'b1;
        live[tail] <= 1'b1;
        mask[tail] <= pushMask & keepMask;
        data[tail] <= pushData;
      end
      count <= count + (LOG+1)'(doPush) - (LOG+1)'(pop);
      if (pushEn & full & ~pop) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/fu0_writeback.sv
// fu0_writeback: latches FU0 result one cycle onto PRF write/bypass, queues completion records to the active list, applies branch squash/clear
module fu0_writeback
  import fu0_writeback_pkg::*;
#(
  parameter int CQ_DEPTH = 4,
  parameter int CQ_LOG = 2
) (
  input logic clk,
  input logic reset,
  fu0_writeback_if.slave bus
);
  logic [CHECKPOINTS-1:0] pktMask, wMask;
  logic [SIZE_PHYSICAL_LOG-1:0] wDest;
  logic [SIZE_DATA-1:0] wResult;
  logic [EXECUTION_FLAGS+SIZE_ACTIVELIST_LOG-1:0] headData;
  logic [CQ_LOG:0] count;
  logic wValid, accept, unusedPktBits;
  assign pktMask = bus.fuPacket_i[FU_PKT_MASK_LSB +: CHECKPOINTS];
  assign accept = bus.fuValid_i & ~killHit(pktMask, bus.ctrlVerified_i, bus.ctrlMispredict_i, bus.ctrlSMTid_i);
  assign unusedPktBits = ^bus.fuPacket_i[FU_PKT_RESULT_LSB-1:0];
  always_ff @(posedge clk) begin
    if (reset | ~accept) begin
      wValid <= 1'b0;
      wDest <= '0;
      wResult <= '0;
      wMask <= '0;
    end else begin
      wValid <= 1'b1;
      wDest <= bus.fuPacket_i[FU_PKT_DEST_LSB +: SIZE_PHYSICAL_LOG];
      wResult <= bus.fuPacket_i[FU_PKT_RESULT_LSB +: SIZE_DATA];
      wMask <= pktMask & clrMask(bus.ctrlVerified_i, bus.ctrlMispredict_i, bus.ctrlSMTid_i);
    end
  end
  // a mispredict resolving during the W cycle suppresses the write combinationally
  assign bus.rfWrEn_o = wValid & ~killHit(wMask, bus.ctrlVerified_i, bus.ctrlMispredict_i, bus.ctrlSMTid_i);
  assign bus.bypassValid_o = bus.rfWrEn_o;
  assign bus.rfWrAddr_o = wDest;
  assign bus.bypassTag_o = wDest;
  assign bus.rfWrData_o = wResult;
  assign bus.bypassData_o = wResult;
  fu_cmpl_queue #(
    .DEPTH(CQ_DEPTH),
    .LOG(CQ_LOG),
    .MASK_W(CHECKPOINTS),
    .ID_W(CHECKPOINTS_LOG),
    .DATA_W(EXECUTION_FLAGS + SIZE_ACTIVELIST_LOG)
  ) cq (
    .clk(clk),
    .reset(reset),
    .pushEn(accept),
    .pushMask(pktMask),
    .pushData({bus.fuPacket_i[FU_PKT_FLAGS_LSB +: EXECUTION_FLAGS], bus.fuPacket_i[FU_PKT_ALID_LSB +: SIZE_ACTIVELIST_LOG]}),
    .verified(bus.ctrlVerified_i),
    .mispredict(bus.ctrlMispredict_i),
    .brId(bus.ctrlSMTid_i),
    .popReady(bus.cmplReady_i),
    .headValid(bus.cmplValid_o),
    .headData(headData),
    .count(count),
    .overflow(bus.overflow_o)
  );
  assign bus.cmplALid_o = headData[SIZE_ACTIVELIST_LOG-1:0];
  assign bus.cmplFlags_o = headData[SIZE_ACTIVELIST_LOG +: EXECUTION_FLAGS];
  // two free slots cover the packet already in flight from issue
  assign bus.fuReady_o = count <= (CQ_LOG+1)'(CQ_DEPTH - 2);
endmodule

// File: tb/tb_fu0_writeback.sv
// tb_fu0_writeback: scoreboard bench for fu0_writeback covering writeback, squash, clear, back-pressure, overflow and reset
module tb_fu0_writeback;
  import fu0_writeback_pkg::*;
  localparam int CQ_DEPTH = 4;
  typedef struct packed {
    logic [SIZE_PHYSICAL_LOG-1:0] dest;
    logic [SIZE_DATA-1:0] res;
    logic [CHECKPOINTS-1:0] mask;
  } wbEnt_t;
  typedef struct packed {
    logic [SIZE_ACTIVELIST_LOG-1:0] alid;
    logic [EXECUTION_FLAGS-1:0] flags;
    logic [CHECKPOINTS-1:0] mask;
  } cEnt_t;
  logic clk, rst;
  int checks = 0, errors = 0;
  wbEnt_t wbQ[$];
  cEnt_t cq[$], tmp[$];
  wbEnt_t we;
  cEnt_t ce;
  fuPkt_t pm;
  logic expEn, popNow;
  logic [CHECKPOINTS-1:0] m;
  fu0_writeback_if bus();
  fu0_writeback #(.CQ_DEPTH(CQ_DEPTH), .CQ_LOG(2)) dut (.clk(clk), .reset(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask
  function automatic logic killB(logic [CHECKPOINTS-1:0] mk);
    return bus.ctrlVerified_i & bus.ctrlMispredict_i & mk[bus.ctrlSMTid_i];
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      wbQ.delete();
      cq.delete();
    end else begin
      expEn = 1'b0;
      we = '0;
      if (wbQ.size() != 0) begin
        we = wbQ.pop_front();
        expEn = ~killB(we.mask);
      end
      check("rfWrEn", 64'(bus.rfWrEn_o), 64'(expEn));
      check("bypassValid", 64'(bus.bypassValid_o), 64'(expEn));
      if (expEn) begin
        check("rfWrAddr", 64'(bus.rfWrAddr_o), 64'(we.dest));
        check("rfWrData", 64'(bus.rfWrData_o), 64'(we.res));
        check("bypassTag", 64'(bus.bypassTag_o), 64'(we.dest));
        check("bypassData", 64'(bus.bypassData_o), 64'(we.res));
      end
      popNow = 1'b0;
      if (bus.cmplValid_o) begin
        if (cq.size() == 0) check("cmplUnexpected", 64'(bus.cmplValid_o), 64'(0));
        else begin
          check("cmplALid", 64'(bus.cmplALid_o), 64'(cq[0].alid));
          check("cmplFlags", 64'(bus.cmplFlags_o), 64'(cq[0].flags));
          popNow = bus.cmplReady_i;
        end
      end
      if (popNow) ce = cq.pop_front();
      if (bus.ctrlVerified_i) begin
        tmp.delete();
        foreach (cq[i]) begin
          ce = cq[i];
          if (!bus.ctrlMispredict_i) ce.mask[bus.ctrlSMTid_i] = 1'b0;
          if (!killB(cq[i].mask)) tmp.push_back(ce);
        end
        cq = tmp;
      end
      pm = fuPkt_t'(bus.fuPacket_i);
      if (bus.fuValid_i && !killB(pm.branchMask)) begin
        m = pm.branchMask;
        if (bus.ctrlVerified_i && !bus.ctrlMispredict_i) m[bus.ctrlSMTid_i] = 1'b0;
        wbQ.push_back('{pm.destReg, pm.result, m});
        if (cq.size() < CQ_DEPTH) cq.push_back('{pm.ALid, pm.flags, m});
      end
    end
  end
  task automatic cyc(input logic v, input logic [CHECKPOINTS-1:0] mk, input logic [SIZE_ACTIVELIST_LOG-1:0] alid,
                     input logic [SIZE_PHYSICAL_LOG-1:0] dest, input logic [SIZE_DATA-1:0] res,
                     input logic ver, input logic misp, input logic [CHECKPOINTS_LOG-1:0] id, input logic rdy);
    fuPkt_t p;
    p = '0;
    p.branchMask = mk;
    p.flags = alid[3:0] ^ 4'h5;
    p.destReg = dest;
    p.ALid = alid;
    p.result = res;
    p.tarAddr = 32'hdead_beef;
    p.brDir = 1'b1;
    bus.fuPacket_i = p;
    bus.fuValid_i = v;
    bus.ctrlVerified_i = ver;
    bus.ctrlMispredict_i = misp;
    bus.ctrlSMTid_i = id;
    bus.cmplReady_i = rdy;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input logic rdy);
    cyc(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0, rdy);
  endtask
  initial begin
    rst = 1'b1;
    bus.fuPacket_i = '0;
    bus.fuValid_i = 1'b0;
    bus.ctrlVerified_i = 1'b0;
    bus.ctrlMispredict_i = 1'b0;
    bus.ctrlSMTid_i = '0;
    bus.cmplReady_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstWrEn", 64'(bus.rfWrEn_o), 64'(0));
    check("rstWrAddr", 64'(bus.rfWrAddr_o), 64'(0));
    check("rstCmplValid", 64'(bus.cmplValid_o), 64'(0));
    check("rstFuReady", 64'(bus.fuReady_o), 64'(1));
    check("rstOverflow", 64'(bus.overflow_o), 64'(0));
    rst = 1'b0;
    idle(1'b1);
    cyc(1'b1, 4'b0000, 6'd3, 7'd5, 32'h1234, 1'b0, 1'b0, 2'd0, 1'b1);
    check("t1WrEn", 64'(bus.rfWrEn_o), 64'(1));
    check("t1WrAddr", 64'(bus.rfWrAddr_o), 64'(5));
    check("t1WrData", 64'(bus.rfWrData_o), 64'h1234);
    check("t1CmplValid", 64'(bus.cmplValid_o), 64'(1));
    check("t1CmplALid", 64'(bus.cmplALid_o), 64'(3));
    idle(1'b1);
    check("t1Drained", 64'(bus.cmplValid_o), 64'(0));
    check("t1FuReady", 64'(bus.fuReady_o), 64'(1));
    cyc(1'b1, 4'b0100, 6'd4, 7'd6, 32'h55, 1'b1, 1'b1, 2'd2, 1'b1);
    check("t2NoWrite", 64'(bus.rfWrEn_o), 64'(0));
    check("t2NoCmpl", 64'(bus.cmplValid_o), 64'(0));
    idle(1'b1);
    check("t2Empty", 64'(bus.cmplValid_o), 64'(0));
    cyc(1'b1, 4'b1000, 6'd20, 7'd9, 32'hAA, 1'b0, 1'b0, 2'd0, 1'b1);
    check("wKillPre", 64'(bus.rfWrEn_o), 64'(1));
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 2'd3, 1'b1);
    idle(1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 4'b0000, 6'(10 + k), 7'(40 + k), 32'(100 + k), 1'b0, 1'b0, 2'd0, 1'b0);
      check("t3FuReady", 64'(bus.fuReady_o), 64'(k < 2));
    end
    cyc(1'b1, 4'b0000, 6'd13, 7'd43, 32'd103, 1'b0, 1'b0, 2'd0, 1'b0);
    check("t3OverflowLow", 64'(bus.overflow_o), 64'(0));
    cyc(1'b1, 4'b0000, 6'd14, 7'd44, 32'd104, 1'b0, 1'b0, 2'd0, 1'b0);
    check("t3OverflowSet", 64'(bus.overflow_o), 64'(1));
    repeat (6) idle(1'b1);
    check("t3Drained", 64'(bus.cmplValid_o), 64'(0));
    check("t3Sticky", 64'(bus.overflow_o), 64'(1));
    cyc(1'b1, 4'b0010, 6'd1, 7'd11, 32'h111, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 4'b0000, 6'd2, 7'd12, 32'h222, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 2'd1, 1'b0);
    check("t4DeadHead", 64'(bus.cmplValid_o), 64'(0));
    idle(1'b0);
    check("t4NextValid", 64'(bus.cmplValid_o), 64'(1));
    check("t4NextALid", 64'(bus.cmplALid_o), 64'(2));
    repeat (2) idle(1'b1);
    cyc(1'b1, 4'b0010, 6'd7, 7'd17, 32'h777, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 2'd1, 1'b0);
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 2'd1, 1'b0);
    check("t5Survives", 64'(bus.cmplValid_o), 64'(1));
    check("t5ALid", 64'(bus.cmplALid_o), 64'(7));
    idle(1'b1);
    check("t5Done", 64'(bus.cmplValid_o), 64'(0));
    for (int k = 0; k < 4; k++) cyc(1'b1, 4'b0000, 6'(30 + k), 7'(50 + k), 32'(300 + k), 1'b0, 1'b0, 2'd0, 1'b0);
    check("t6WValid", 64'(bus.rfWrEn_o), 64'(1));
    rst = 1'b1;
    cyc(1'b1, 4'b0000, 6'd35, 7'd55, 32'd305, 1'b1, 1'b1, 2'd0, 1'b1);
    check("t6WrEn", 64'(bus.rfWrEn_o), 64'(0));
    check("t6WrAddr", 64'(bus.rfWrAddr_o), 64'(0));
    check("t6WrData", 64'(bus.rfWrData_o), 64'(0));
    check("t6BypassValid", 64'(bus.bypassValid_o), 64'(0));
    check("t6CmplValid", 64'(bus.cmplValid_o), 64'(0));
    check("t6CmplALid", 64'(bus.cmplALid_o), 64'(0));
    check("t6FuReady", 64'(bus.fuReady_o), 64'(1));
    check("t6Overflow", 64'(bus.overflow_o), 64'(0));
    rst = 1'b0;
    for (int k = 0; k < 80; k++)
      cyc(bus.fuReady_o & 1'($urandom_range(0, 1)), 4'($urandom), 6'($urandom), 7'($urandom), $urandom,
          $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 1)));
    repeat (10) idle(1'b1);
    check("endCmplModel", 64'(cq.size()), 64'(0));
    check("endWbModel", 64'(wbQ.size()), 64'(0));
    check("endOverflow", 64'(bus.overflow_o), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
